// File: rtl/servo_slew_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
//   Shared widths, register field offsets, channel state encoding and a
//   small step helper for the servo slew controller.
//   No ports (package).
// -----------------------------------------------------------------------------
package servo_pkg;

  localparam int POS_W    = 8;   // position width (PWM channel width)
  localparam int RATE_W   = 8;   // ticks-per-step width
  localparam int DATA_W   = 16;  // register data width
  localparam int RATE_LSB = 8;   // Rate field offset in register data
  localparam int TGT_LSB  = 0;   // Target field offset in write data

  localparam logic [POS_W-1:0] INIT_POS_DEFAULT = 8'h80;

  // Channel condition, derived every cycle from CurPos/Target/Rate.
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,  // CurPos == Target
    ST_SNAP = 2'd1,  // Rate == 0, jump straight to Target
    ST_RAMP = 2'd2   // Rate != 0, one LSB every Rate ticks
  } chan_state_e;

  // One LSB toward tgt; never passes it, so the 0x00/0xFF ends cannot wrap.
  function automatic logic [POS_W-1:0] step_toward(input logic [POS_W-1:0] cur,
                                                   input logic [POS_W-1:0] tgt);
    logic [POS_W-1:0] res;
    res = cur;
    if (cur < tgt) begin
      res = cur + POS_W'(1);
    end else if (cur > tgt) begin
      res = cur - POS_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_slew_chan.sv
// -----------------------------------------------------------------------------
// servo_slew_chan
//   One servo channel: Target, Rate, CurPos and the tick sub-counter plus the
//   HOLD/SNAP/RAMP step logic.
// Ports
//   Clk       in   system clock, posedge
//   nReset    in   asynchronous active-low reset
//   Tick      in   one-cycle slew tick from the shared prescaler
//   Load      in   write strobe for this channel (wins over Tick)
//   LoadData  in   {Rate[15:8], Target[7:0]}
//   CurPos    out  current position (registered)
//   Rate      out  programmed rate (registered, for read-back)
//   Busy      out  CurPos != Target
// -----------------------------------------------------------------------------
module servo_slew_chan
  import servo_pkg::*;
#(
  parameter logic [POS_W-1:0] INIT_POS = INIT_POS_DEFAULT
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Tick,
  input  logic              Load,
  input  logic [DATA_W-1:0] LoadData,
  output logic [POS_W-1:0]  CurPos,
  output logic [RATE_W-1:0] Rate,
  output logic              Busy
);

  logic [POS_W-1:0]  cur_pos_q, cur_pos_d;
  logic [POS_W-1:0]  tgt_q, tgt_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] int_cnt_q, int_cnt_d;
  chan_state_e       state;

  always_comb begin
    if (cur_pos_q == tgt_q) begin
      state = ST_HOLD;
    end else if (rate_q == '0) begin
      state = ST_SNAP;
    end else begin
      state = ST_RAMP;
    end
  end

  always_comb begin
    cur_pos_d = cur_pos_q;
    tgt_d     = tgt_q;
    rate_d    = rate_q;
    int_cnt_d = int_cnt_q;
    if (Load) begin
      // A write restarts the sub-count and suppresses any coincident Tick;
      // CurPos is untouched so a retarget never loses or repeats a step.
      tgt_d     = LoadData[TGT_LSB +: POS_W];
      rate_d    = LoadData[RATE_LSB +: RATE_W];
      int_cnt_d = '0;
    end else begin
      unique case (state)
        ST_HOLD: int_cnt_d = '0;
        ST_SNAP: cur_pos_d = tgt_q;
        ST_RAMP: begin
          if (Tick) begin
            // int_cnt_q < rate_q always holds (cleared on load and on step),
            // so the +1 cannot overflow.
            if (int_cnt_q + RATE_W'(1) == rate_q) begin
              cur_pos_d = step_toward(cur_pos_q, tgt_q);
              int_cnt_d = '0;
            end else begin
              int_cnt_d = int_cnt_q + RATE_W'(1);
            end
          end
        end
        default: int_cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cur_pos_q <= INIT_POS;
      tgt_q     <= INIT_POS;
      rate_q    <= '0;
      int_cnt_q <= '0;
    end else begin
      cur_pos_q <= cur_pos_d;
      tgt_q     <= tgt_d;
      rate_q    <= rate_d;
      int_cnt_q <= int_cnt_d;
    end
  end

  assign CurPos = cur_pos_q;
  assign Rate   = rate_q;
  assign Busy   = (state != ST_HOLD);

endmodule

// File: rtl/servo_slew_ctrl.sv
// -----------------------------------------------------------------------------
// servo_slew_ctrl
//   Multi-channel servo position slew controller feeding the PWM stage.
//   Holds the shared tick prescaler, register address decode and read mux;
//   each channel is a servo_slew_chan.
// Ports
//   Clk       in   system clock, posedge
//   nReset    in   asynchronous active-low reset
//   WrEn      in   one-cycle register write strobe
//   Addr      in   channel select for read and write
//   DataWr    in   {Rate[15:8], Target[7:0]}
//   DataRd    out  {Rate[15:8], CurPos[7:0]} of Addr, 0 when out of range
//   ChanPos   out  packed CurPos, channel i at [8i+7:8i]
//   Busy      out  per-channel CurPos != Target
// -----------------------------------------------------------------------------
module servo_slew_ctrl
  import servo_pkg::*;
#(
  parameter int               NUM_SERVO = 2,
  parameter int               ADDR_W    = 5,
  parameter int               TICK_DIV  = 4000,
  parameter logic [POS_W-1:0] INIT_POS  = INIT_POS_DEFAULT
) (
  input  logic                       Clk,
  input  logic                       nReset,
  input  logic                       WrEn,
  input  logic [ADDR_W-1:0]          Addr,
  input  logic [DATA_W-1:0]          DataWr,
  output logic [DATA_W-1:0]          DataRd,
  output logic [NUM_SERVO*POS_W-1:0] ChanPos,
  output logic [NUM_SERVO-1:0]       Busy
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]     presc_q, presc_d;
  logic                 tick;
  logic [NUM_SERVO-1:0] load;
  logic [POS_W-1:0]     cur_pos [NUM_SERVO];
  logic [RATE_W-1:0]    rate    [NUM_SERVO];

  // Free-running prescaler; tick is decoded from the registered count.
  assign tick = (presc_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q + CNT_W'(1);
    if (tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SERVO; gi++) begin : g_chan
      // Out-of-range addresses match no channel, so such writes are dropped.
      assign load[gi] = WrEn && (Addr == ADDR_W'(gi));

      servo_slew_chan #(
        .INIT_POS (INIT_POS)
      ) u_chan (
        .Clk      (Clk),
        .nReset   (nReset),
        .Tick     (tick),
        .Load     (load[gi]),
        .LoadData (DataWr),
        .CurPos   (cur_pos[gi]),
        .Rate     (rate[gi]),
        .Busy     (Busy[gi])
      );

      assign ChanPos[gi*POS_W +: POS_W] = cur_pos[gi];
    end
  endgenerate

  always_comb begin
    DataRd = '0;
    for (int i = 0; i < NUM_SERVO; i++) begin
      if (Addr == ADDR_W'(i)) begin
        DataRd = {rate[i], cur_pos[i]};
      end
    end
  end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
module tb_servo_slew_ctrl;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        WrEn = 1'b0;
  logic [4:0]  Addr = '0;
  logic [15:0] DataWr = '0;
  logic [15:0] DataRd;
  logic [15:0] ChanPos;
  logic [1:0]  Busy;

  servo_slew_ctrl #(
    .NUM_SERVO (2),
    .ADDR_W    (5),
    .TICK_DIV  (4),
    .INIT_POS  (8'h80)
  ) dut (
    .Clk     (Clk),
    .nReset  (nReset),
    .WrEn    (WrEn),
    .Addr    (Addr),
    .DataWr  (DataWr),
    .DataRd  (DataRd),
    .ChanPos (ChanPos),
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] cp;
    logic [1:0]  bz;
    logic [15:0] rd;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] data;
    int          cyc;   // edges to apply; state is constant over the stretch
    logic [15:0] cp;
    logic [1:0]  bz;
    logic [15:0] rd;
  } vec_t;

  exp_t  exp_q[$];
  vec_t  tbl[$];
  int    n_vec = 0;
  int    n_miss = 0;
  string tag = "";

  task automatic check(input exp_t e);
    n_vec++;
    if (ChanPos !== e.cp) begin
      n_miss++;
      $display("FAIL %s #%0d ChanPos: got %h expected %h", tag, n_vec, ChanPos, e.cp);
    end
    if (Busy !== e.bz) begin
      n_miss++;
      $display("FAIL %s #%0d Busy: got %b expected %b", tag, n_vec, Busy, e.bz);
    end
    if (DataRd !== e.rd) begin
      n_miss++;
      $display("FAIL %s #%0d DataRd: got %h expected %h", tag, n_vec, DataRd, e.rd);
    end
    $display("%s #%0d wr=%0b addr=%0d ChanPos=%h Busy=%b DataRd=%h", tag, n_vec, WrEn,
             Addr, ChanPos, Busy, DataRd);
  endtask

  // Drive one edge of stimulus, queue its expectation, compare after the edge.
  task automatic cycle(input logic wr, input logic [4:0] a, input logic [15:0] d,
                       input logic [15:0] ecp, input logic [1:0] ebz, input logic [15:0] erd);
    exp_t e;
    WrEn   = wr;
    Addr   = a;
    DataWr = d;
    exp_q.push_back('{cp: ecp, bz: ebz, rd: erd});
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check(e);
  endtask

  task automatic idle(input int n, input logic [4:0] a, input logic [15:0] ecp,
                      input logic [1:0] ebz, input logic [15:0] erd);
    for (int i = 0; i < n; i++) cycle(1'b0, a, 16'h0000, ecp, ebz, erd);
  endtask

  // Leaves the bench 1 time unit after an edge, prescaler at 0 for the next edge.
  task automatic do_reset();
    WrEn   = 1'b0;
    Addr   = '0;
    DataWr = '0;
    nReset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    nReset = 1'b1;
  endtask

  initial begin
    // Basic sequence: snap on ch0, rate-2 ramp on ch1 (ticks at edges 4,8,...).
    tbl.push_back('{1'b1, 5'd0, 16'h0010, 1, 16'h8080, 2'b01, 16'h0080});
    tbl.push_back('{1'b0, 5'd0, 16'h0000, 1, 16'h8010, 2'b00, 16'h0010});
    tbl.push_back('{1'b1, 5'd1, 16'h0283, 1, 16'h8010, 2'b10, 16'h0280});
    tbl.push_back('{1'b0, 5'd1, 16'h0000, 4, 16'h8010, 2'b10, 16'h0280});
    tbl.push_back('{1'b0, 5'd1, 16'h0000, 1, 16'h8110, 2'b10, 16'h0281});
    tbl.push_back('{1'b0, 5'd1, 16'h0000, 7, 16'h8110, 2'b10, 16'h0281});
    tbl.push_back('{1'b0, 5'd1, 16'h0000, 1, 16'h8210, 2'b10, 16'h0282});
    tbl.push_back('{1'b0, 5'd1, 16'h0000, 7, 16'h8210, 2'b10, 16'h0282});
    tbl.push_back('{1'b0, 5'd1, 16'h0000, 1, 16'h8310, 2'b00, 16'h0283});
    tbl.push_back('{1'b0, 5'd1, 16'h0000, 8, 16'h8310, 2'b00, 16'h0283});
    tbl.push_back('{1'b1, 5'd7, 16'h05AA, 1, 16'h8310, 2'b00, 16'h0000});
    tbl.push_back('{1'b0, 5'd0, 16'h0000, 1, 16'h8310, 2'b00, 16'h0010});
    tbl.push_back('{1'b1, 5'd1, 16'h0583, 1, 16'h8310, 2'b00, 16'h0583});

    // Reset state
    tag = "reset";
    do_reset();
    Addr = 5'd0;
    #1;
    check('{cp: 16'h8080, bz: 2'b00, rd: 16'h0080});
    #1;  // back on a 1-unit-after-edge-aligned schedule is not required for cycle()

    tag = "table";
    for (int v = 0; v < tbl.size(); v++) begin
      for (int c = 0; c < tbl[v].cyc; c++) begin
        cycle(tbl[v].wr, tbl[v].addr, tbl[v].data, tbl[v].cp, tbl[v].bz, tbl[v].rd);
      end
    end

    // Reverse mid-ramp: ch0 rate 1 toward 0x90, retarget to 0x80 after 0x82.
    tag = "reverse";
    do_reset();
    cycle(1'b1, 5'd0, 16'h0190, 16'h8080, 2'b01, 16'h0180);   // edge 1
    idle(2, 5'd0, 16'h8080, 2'b01, 16'h0180);                 // edges 2-3
    idle(1, 5'd0, 16'h8081, 2'b01, 16'h0181);                 // edge 4
    idle(3, 5'd0, 16'h8081, 2'b01, 16'h0181);
    idle(1, 5'd0, 16'h8082, 2'b01, 16'h0182);                 // edge 8
    cycle(1'b1, 5'd0, 16'h0180, 16'h8082, 2'b01, 16'h0182);   // edge 9
    idle(2, 5'd0, 16'h8082, 2'b01, 16'h0182);
    idle(1, 5'd0, 16'h8081, 2'b01, 16'h0181);                 // edge 12
    idle(3, 5'd0, 16'h8081, 2'b01, 16'h0181);
    idle(1, 5'd0, 16'h8080, 2'b00, 16'h0180);                 // edge 16
    idle(8, 5'd0, 16'h8080, 2'b00, 16'h0180);

    // Write colliding with a Tick on ch0 while ch1 ramps through the same Tick.
    tag = "collide";
    do_reset();
    cycle(1'b1, 5'd0, 16'h0290, 16'h8080, 2'b01, 16'h0280);   // edge 1
    cycle(1'b1, 5'd1, 16'h0184, 16'h8080, 2'b11, 16'h0180);   // edge 2
    idle(1, 5'd0, 16'h8080, 2'b11, 16'h0280);                 // edge 3
    idle(1, 5'd0, 16'h8180, 2'b11, 16'h0280);                 // edge 4 (ch0 cnt 1)
    idle(3, 5'd0, 16'h8180, 2'b11, 16'h0280);
    cycle(1'b1, 5'd0, 16'h0290, 16'h8280, 2'b11, 16'h0280);   // edge 8 tick+write
    idle(3, 5'd0, 16'h8280, 2'b11, 16'h0280);
    idle(1, 5'd0, 16'h8380, 2'b11, 16'h0280);                 // edge 12
    idle(3, 5'd0, 16'h8380, 2'b11, 16'h0280);
    idle(1, 5'd0, 16'h8481, 2'b01, 16'h0281);                 // edge 16
    cycle(1'b1, 5'd0, 16'h0281, 16'h8481, 2'b00, 16'h0281);   // target == CurPos
    idle(4, 5'd0, 16'h8481, 2'b00, 16'h0281);

    // Asynchronous reset in the middle of a ramp.
    tag = "async_rst";
    do_reset();
    cycle(1'b1, 5'd1, 16'h0283, 16'h8080, 2'b10, 16'h0280);
    idle(6, 5'd1, 16'h8080, 2'b10, 16'h0280);
    idle(1, 5'd1, 16'h8180, 2'b10, 16'h0281);
    idle(2, 5'd1, 16'h8180, 2'b10, 16'h0281);
    #2;
    nReset = 1'b0;
    #1;
    check('{cp: 16'h8080, bz: 2'b00, rd: 16'h0080});
    #2;
    nReset = 1'b1;
    @(posedge Clk);
    #1;
    idle(16, 5'd1, 16'h8080, 2'b00, 16'h0080);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
